// File: rtl/store_aligner_queue.sv
// store_aligner_queue
//
// Write-side store path for the memory stage. SB/SH/SW stores are aligned into
// big-endian byte lanes (byte offset 0 = bits [31:24]) with matching per-byte
// write enables, then buffered in a small in-order FIFO and drained to data
// memory over a valid/ready port. Misaligned SH/SW stores are dropped and
// flagged for one cycle. Loads in the memory stage are compared against every
// pending store word so the pipeline can stall on a read-after-write hazard.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   st_valid       : store request valid
//   st_ready       : queue can accept (not full); depends on registered state only
//   st_opcode      : 6-bit opcode; SB, SH and SW are enqueued, others are absorbed
//   st_addr        : byte address of the store
//   st_data        : LSB-justified store data
//   mem_valid      : head entry valid (queue not empty)
//   mem_ready      : memory accepts the head entry
//   mem_addr       : word-aligned address of the head entry
//   mem_wdata      : lane-aligned write data of the head entry
//   mem_we         : byte enables of the head entry, bit3 = bits [31:24]
//   misaligned     : registered one-cycle pulse after a misaligned SH/SW
//   ld_check_addr  : address of the load currently in the memory stage
//   ld_hazard      : a pending store targets the same word as ld_check_addr
//   empty          : queue holds no entries
module store_aligner_queue #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [5:0]  st_opcode,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        misaligned,
  input  logic [31:0] ld_check_addr,
  output logic        ld_hazard,
  output logic        empty
);

  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } entry_t;

  entry_t                entries_q [DEPTH];
  entry_t                entries_d [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  misaligned_q, misaligned_d;

  logic [31:0] align_wdata;
  logic [3:0]  align_we;
  logic        align_ok;
  logic        align_bad;
  logic        accept;
  logic        enq;
  logic        deq;
  logic        unused_addr_bits;

  // The byte offset of the load does not matter: hazards are checked per word.
  assign unused_addr_bits = ^ld_check_addr[1:0];

  assign st_ready   = (count_q != FULL_COUNT);
  assign mem_valid  = (count_q != '0);
  assign empty      = (count_q == '0);
  assign misaligned = misaligned_q;

  // Head outputs are forced to zero while empty so that a drained or reset
  // queue never shows a stale entry on the memory port.
  assign mem_addr  = mem_valid ? {entries_q[head_q].waddr, 2'b00} : '0;
  assign mem_wdata = mem_valid ? entries_q[head_q].wdata : '0;
  assign mem_we    = mem_valid ? entries_q[head_q].we : '0;

  assign accept = st_valid & st_ready;
  assign enq    = accept & align_ok;
  assign deq    = mem_valid & mem_ready;

  // Lane alignment: replicate the store data across the word and select the
  // target lanes with the byte enables. Unknown opcodes neither enqueue nor flag.
  always_comb begin
    align_wdata = '0;
    align_we    = '0;
    align_ok    = 1'b0;
    align_bad   = 1'b0;
    if (st_opcode == OP_SB) begin
      align_wdata = {4{st_data[7:0]}};
      align_we    = 4'b1000 >> st_addr[1:0];
      align_ok    = 1'b1;
    end else if (st_opcode == OP_SH) begin
      if (st_addr[0]) begin
        align_bad = 1'b1;
      end else begin
        align_wdata = {2{st_data[15:0]}};
        align_we    = st_addr[1] ? 4'b0011 : 4'b1100;
        align_ok    = 1'b1;
      end
    end else if (st_opcode == OP_SW) begin
      if (st_addr[1:0] != 2'b00) begin
        align_bad = 1'b1;
      end else begin
        align_wdata = st_data;
        align_we    = 4'b1111;
        align_ok    = 1'b1;
      end
    end
  end

  // FIFO next state. Full blocks acceptance, so enqueue and dequeue never
  // target the same slot in one cycle.
  always_comb begin
    entries_d    = entries_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    misaligned_d = accept & align_bad;
    if (enq) begin
      entries_d[tail_q] = '{waddr: st_addr[31:2], wdata: align_wdata, we: align_we};
      tail_d            = tail_q + 1'b1;
    end
    if (deq) begin
      head_d = head_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [DEPTH_LOG2-1:0] offset;
    offset    = '0;
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = DEPTH_LOG2'(i) - head_q;
      if (({1'b0, offset} < count_q) &&
          (entries_q[i].waddr == ld_check_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_store_aligner_queue.sv
// tb_store_aligner_queue
//
// Drives directed and random store/drain traffic into store_aligner_queue and
// compares every observable output against a queue-based reference model that
// applies the alignment rules arithmetically.
module tb_store_aligner_queue;

  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam int         QDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [5:0]  st_opcode;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        misaligned;
  logic [31:0] ld_check_addr;
  logic        ld_hazard;
  logic        empty;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } model_entry_t;

  model_entry_t modelQueue[$];
  logic         modelMisaligned;
  int           checkCount = 0;
  int           errorCount = 0;

  always #5 clk = ~clk;

  store_aligner_queue #(.DEPTH(4), .DEPTH_LOG2(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_opcode     (st_opcode),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .misaligned    (misaligned),
    .ld_check_addr (ld_check_addr),
    .ld_hazard     (ld_hazard),
    .empty         (empty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every output against the model, then advance the model by one
  // clock using the handshake rules and the lane-alignment arithmetic.
  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] d, input logic mr, input logic [31:0] la);
    logic         expHazard;
    logic         acc;
    int           off;
    model_entry_t e;
    st_valid      = v;
    st_opcode     = op;
    st_addr       = a;
    st_data       = d;
    mem_ready     = mr;
    ld_check_addr = la;
    #1;
    checkOutput("mem_valid", 32'(mem_valid), 32'(modelQueue.size() != 0));
    checkOutput("st_ready", 32'(st_ready), 32'(modelQueue.size() != QDEPTH));
    checkOutput("empty", 32'(empty), 32'(modelQueue.size() == 0));
    checkOutput("misaligned", 32'(misaligned), 32'(modelMisaligned));
    expHazard = 1'b0;
    foreach (modelQueue[i]) begin
      if (modelQueue[i].waddr == la[31:2]) expHazard = 1'b1;
    end
    checkOutput("ld_hazard", 32'(ld_hazard), 32'(expHazard));
    if (modelQueue.size() != 0) begin
      checkOutput("mem_addr", mem_addr, {modelQueue[0].waddr, 2'b00});
      checkOutput("mem_wdata", mem_wdata, modelQueue[0].wdata);
      checkOutput("mem_we", 32'(mem_we), 32'(modelQueue[0].we));
    end

    acc = v && (modelQueue.size() != QDEPTH);
    if (mr && modelQueue.size() != 0) void'(modelQueue.pop_front());
    modelMisaligned = 1'b0;
    if (acc) begin
      off     = int'(a[1:0]);
      e.waddr = a[31:2];
      if (op == OP_SB) begin
        e.wdata = 32'(d[7:0]) * 32'h0101_0101;
        e.we    = 4'(1 << (3 - off));
        modelQueue.push_back(e);
      end else if (op == OP_SH) begin
        if (off % 2 != 0) begin
          modelMisaligned = 1'b1;
        end else begin
          e.wdata = 32'(d[15:0]) * 32'h0001_0001;
          e.we    = (off == 2) ? 4'd3 : 4'd12;
          modelQueue.push_back(e);
        end
      end else if (op == OP_SW) begin
        if (off != 0) begin
          modelMisaligned = 1'b1;
        end else begin
          e.wdata = d;
          e.we    = 4'd15;
          modelQueue.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset between clock edges and check that the queue clears at once.
  task automatic resetPulse(input logic [31:0] la);
    ld_check_addr = la;
    st_valid      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelQueue.delete();
    modelMisaligned = 1'b0;
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_st_ready", 32'(st_ready), 32'd1);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_misaligned", 32'(misaligned), 32'd0);
    checkOutput("rst_ld_hazard", 32'(ld_hazard), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    st_valid        = 1'b0;
    st_opcode       = '0;
    st_addr         = '0;
    st_data         = '0;
    mem_ready       = 1'b0;
    ld_check_addr   = '0;
    modelMisaligned = 1'b0;
    @(posedge clk);
    #1;
    resetPulse(32'h0);

    // Byte store at the last lane, drained immediately.
    applyStimulus(1, OP_SB, 32'h1003, 32'h0000_00AB, 1, 32'h0);
    applyStimulus(0, OP_SB, 32'h0, 32'h0, 1, 32'h1000);
    applyStimulus(0, OP_SB, 32'h0, 32'h0, 1, 32'h1000);

    // Halfword lanes and a full word.
    applyStimulus(1, OP_SH, 32'h2002, 32'h0000_1234, 1, 32'h0);
    applyStimulus(1, OP_SH, 32'h2000, 32'h0000_1234, 1, 32'h0);
    applyStimulus(1, OP_SW, 32'h3000, 32'hDEAD_BEEF, 1, 32'h0);
    applyStimulus(0, OP_SW, 32'h0, 32'h0, 1, 32'h0);
    applyStimulus(0, OP_SW, 32'h0, 32'h0, 1, 32'h0);

    // Fill while stalled, hold off a fifth store, then drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(1, OP_SW, 32'(4 * i), 32'h100 + 32'(i), 0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1, OP_SW, 32'h10, 32'h555, 0, 32'h8);
    for (int i = 0; i < 7; i++) applyStimulus(1, OP_SW, 32'h10, 32'h555, 1, 32'h10);
    applyStimulus(0, OP_SW, 32'h0, 32'h0, 1, 32'h0);

    // Misaligned stores and an ignored opcode leave the queue empty.
    applyStimulus(1, OP_SW, 32'h4001, 32'h1, 0, 32'h4000);
    applyStimulus(1, OP_SH, 32'h4003, 32'h2, 0, 32'h4000);
    applyStimulus(1, OP_LW, 32'h4000, 32'h3, 0, 32'h4000);
    applyStimulus(0, OP_SW, 32'h0, 32'h0, 0, 32'h4000);

    // Load hazard against a pending byte store, before and after draining.
    applyStimulus(1, OP_SB, 32'h1003, 32'h77, 0, 32'h1000);
    applyStimulus(0, OP_SB, 32'h0, 32'h0, 0, 32'h1000);
    applyStimulus(0, OP_SB, 32'h0, 32'h0, 1, 32'h1004);
    applyStimulus(0, OP_SB, 32'h0, 32'h0, 1, 32'h1000);

    // Asynchronous reset with entries pending; nothing stale may reappear.
    for (int i = 0; i < 3; i++) applyStimulus(1, OP_SW, 32'h2000 + 32'(4 * i), 32'h9 + 32'(i), 0, 32'h0);
    resetPulse(32'h2000);
    applyStimulus(0, OP_SW, 32'h0, 32'h0, 1, 32'h2000);
    applyStimulus(0, OP_SW, 32'h0, 32'h0, 1, 32'h2004);

    // Random traffic over a small address window to exercise wrap and hazards.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 3))
        0:       op = OP_SB;
        1:       op = OP_SH;
        2:       op = OP_SW;
        default: op = OP_LW;
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), op, 32'h1000 + 32'($urandom_range(0, 15)),
                    $urandom, ($urandom_range(0, 1) == 1), 32'h1000 + 32'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
